// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and the
// handshake FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add unsigned multiplier, one iteration per clock.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   start       - latch operands and clear the accumulator
//   a, b        - multiplicand and multiplier (sampled on start)
//   done        - high during the cycle whose edge completes the last iteration
//   prod_next   - accumulator value after this cycle's iteration; the full
//                 product when done is high
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  // Low half starts as the multiplier and fills with product bits as it shifts.
  logic [WIDTH-1:0] lo_q;
  logic [CNTW-1:0]  cnt_q;
  logic             run_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  always_comb begin
    addend    = lo_q[0] ? mcand_q : '0;
    sum       = {1'b0, hi_q} + {1'b0, addend};
    prod_next = {sum, lo_q[WIDTH-1:1]};
    done      = run_q && (cnt_q == CNTW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      mcand_q <= a;
      hi_q    <= '0;
      lo_q    <= b;
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      {hi_q, lo_q} <= prod_next;
      if (done) begin
        cnt_q <= '0;
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: AND/OR/ADD/SUB/SLT/NOR in one cycle, unsigned
// multiply over WIDTH cycles. Valid/ready on both sides, registered outputs.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   in_valid/in_ready    - request handshake; in1, in2, op sampled on accept
//   out_valid/out_ready  - result handshake; outputs held while stalled
//   res, res_hi          - result / product halves (res_hi 0 unless MULU)
//   cout, overflow, zero - adder carry, signed overflow, res == 0
//   busy                 - multiply in progress
//   op_err               - accepted op code was undefined
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             op_err
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  alu_state_e       state_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             err_q;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  // Single-cycle datapath
  logic             sub_like;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;
  logic             alu_err;
  logic             alu_zero;

  always_comb begin
    sub_like = (op == OP_SUB) || (op == OP_SLT);
    b_x      = sub_like ? ~in2 : in2;
    sum      = {1'b0, in1} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub_like};
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    add_ovf  = (in1[WIDTH-1] ^ b_x[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];

    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_err  = 1'b0;
    case (op)
      OP_AND: alu_res = in1 & in2;
      OP_OR:  alu_res = in1 | in2;
      OP_NOR: alu_res = ~(in1 | in2);
      OP_ADD, OP_SUB: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = add_ovf;
      end
      OP_SLT: begin
        alu_res[0] = sum[WIDTH-1] ^ add_ovf;
        alu_cout   = sum[WIDTH];
      end
      OP_MULU: ;
      default: alu_err = 1'b1;
    endcase
    alu_zero = !alu_err && (alu_res == '0);
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    accept    = in_valid && in_ready;
    mul_start = accept && (op == OP_MULU);
  end

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .a         (in1),
    .b         (in2),
    .done      (mul_done),
    .prod_next (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      res_q    <= '0;
      res_hi_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      err_q <= alu_err;
      if (op == OP_MULU) begin
        // Result registers keep the previous value until the product lands.
        state_q <= ST_MUL;
      end else begin
        state_q  <= ST_DONE;
        res_q    <= alu_res;
        res_hi_q <= '0;
        cout_q   <= alu_cout;
        ovf_q    <= alu_ovf;
        zero_q   <= alu_zero;
      end
    end else if ((state_q == ST_MUL) && mul_done) begin
      state_q           <= ST_DONE;
      {res_hi_q, res_q} <= mul_prod;
      cout_q            <= 1'b0;
      ovf_q             <= 1'b0;
      zero_q            <= (mul_prod[WIDTH-1:0] == '0);
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_q <= ST_IDLE;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_MUL);
  assign res       = res_q;
  assign res_hi    = res_hi_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign op_err    = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): vector table for single-cycle
// ops plus hand-written multiply, backpressure and reset sequences.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [31:0] res_hi;
  logic        cout;
  logic        overflow;
  logic        zero;
  logic        busy;
  logic        op_err;

  int checks   = 0;
  int failures = 0;

  alu_mc #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_hi    (res_hi),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .busy      (busy),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        e;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one single-cycle op and check its result one cycle later.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    in_valid  = 1'b1;
    op        = v.op;
    in1       = v.a;
    in2       = v.b;
    out_ready = 1'b1;
    #1 check($sformatf("v%0d in_ready", idx), {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in1      = $urandom;
    in2      = $urandom;
    check($sformatf("v%0d out_valid", idx), {63'd0, out_valid}, 64'd1);
    check($sformatf("v%0d res", idx), {32'd0, res}, {32'd0, v.r});
    check($sformatf("v%0d res_hi", idx), {32'd0, res_hi}, 64'd0);
    check($sformatf("v%0d cout", idx), {63'd0, cout}, {63'd0, v.c});
    check($sformatf("v%0d overflow", idx), {63'd0, overflow}, {63'd0, v.v});
    check($sformatf("v%0d zero", idx), {63'd0, zero}, {63'd0, v.z});
    check($sformatf("v%0d op_err", idx), {63'd0, op_err}, {63'd0, v.e});
  endtask

  // Full-timing multiply: busy for 32 cycles, result on the 32nd.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic ez);
    @(negedge clk);
    in_valid  = 1'b1;
    op        = OP_MULU;
    in1       = a;
    in2       = b;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in1      = $urandom;
      in2      = $urandom;
      op       = OP_ADD;
      check($sformatf("mul c%0d busy", i), {63'd0, busy}, 64'd1);
      check($sformatf("mul c%0d in_ready", i), {63'd0, in_ready}, 64'd0);
      check($sformatf("mul c%0d out_valid", i), {63'd0, out_valid}, 64'd0);
    end
    @(negedge clk);
    check("mul out_valid", {63'd0, out_valid}, 64'd1);
    check("mul busy end", {63'd0, busy}, 64'd0);
    check("mul prod", {res_hi, res}, {ehi, elo});
    check("mul cout", {63'd0, cout}, 64'd0);
    check("mul overflow", {63'd0, overflow}, 64'd0);
    check("mul zero", {63'd0, zero}, {63'd0, ez});
    check("mul op_err", {63'd0, op_err}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_AND,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{OP_OR,   32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_SLT,  32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{OP_NOR,  32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_SUB,  32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{OP_SUB,  32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    op        = OP_AND;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst out_valid", {63'd0, out_valid}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst in_ready", {63'd0, in_ready}, 64'd1);
    check("rst res", {res_hi, res}, 64'd0);
    check("rst flags", {60'd0, cout, overflow, zero, op_err}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_mul(32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1);
    run_mul(32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0);

    // Backpressure: ADD held for 5 cycles while an OR waits at the input.
    @(negedge clk);
    in_valid  = 1'b1;
    op        = OP_ADD;
    in1       = 32'h7FFFFFFF;
    in2       = 32'h00000001;
    out_ready = 1'b0;
    @(negedge clk);
    op  = OP_OR;
    in1 = 32'hA5A5A5A5;
    in2 = 32'h5A5A5A5A;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp c%0d out_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp c%0d in_ready", i), {63'd0, in_ready}, 64'd0);
      check($sformatf("bp c%0d res", i), {32'd0, res}, 64'h80000000);
      check($sformatf("bp c%0d flags", i), {60'd0, cout, overflow, zero, op_err}, 64'h4);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp release in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b out_valid", {63'd0, out_valid}, 64'd1);
    check("b2b res", {32'd0, res}, 64'hFFFFFFFF);
    check("b2b flags", {60'd0, cout, overflow, zero, op_err}, 64'd0);
    @(negedge clk);
    check("idle out_valid", {63'd0, out_valid}, 64'd0);
    check("idle res held", {32'd0, res}, 64'hFFFFFFFF);

    // Reset on multiply iteration 10, with a request presented during reset.
    @(negedge clk);
    in_valid = 1'b1;
    op       = OP_MULU;
    in1      = 32'hFFFFFFFF;
    in2      = 32'hFFFFFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-rst busy", {63'd0, busy}, 64'd1);
    reset    = 1'b1;
    in_valid = 1'b1;
    op       = OP_ADD;
    in1      = 32'd1;
    in2      = 32'd1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    check("mrst out_valid", {63'd0, out_valid}, 64'd0);
    check("mrst busy", {63'd0, busy}, 64'd0);
    check("mrst in_ready", {63'd0, in_ready}, 64'd1);
    check("mrst res", {res_hi, res}, 64'd0);
    check("mrst flags", {60'd0, cout, overflow, zero, op_err}, 64'd0);
    @(negedge clk);
    check("mrst ignored req", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1;
    op       = OP_ADD;
    in1      = 32'd3;
    in2      = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    check("post-rst out_valid", {63'd0, out_valid}, 64'd1);
    check("post-rst res", {res_hi, res}, 64'd7);
    check("post-rst flags", {60'd0, cout, overflow, zero, op_err}, 64'd0);
    @(negedge clk);
    check("post-rst idle", {63'd0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
